// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between N_REQ byte producers.
// One byte per grant; waits out the full frame and flags a silent transmitter.
`timescale 1ns/1ps
module uart_tx_arbiter #(
  parameter int N_REQ       = 4,
  parameter int DATA_WIDTH  = 8,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [N_REQ-1:0]            req_valid,
  input  logic [N_REQ*DATA_WIDTH-1:0] req_data,
  output logic [N_REQ-1:0]            req_ack,
  input  logic                        tx_busy,
  output logic [DATA_WIDTH-1:0]       tx_data,
  output logic                        tx_send,
  output logic [2:0]                  grant_id,
  output logic                        active,
  input  logic                        err_clear,
  output logic                        timeout_err
);

  localparam int CW = $clog2(ACK_TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_BUSY,
    WAIT_DONE
  } state_t;

  state_t                  state_q, state_d;
  logic [2:0]              last_q, last_d;
  logic [2:0]              grant_q, grant_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic                    err_q, err_d;

  logic [2*N_REQ-1:0]      dbl;
  logic [N_REQ-1:0]        rot;
  logic                    found;
  logic [2:0]              pos;
  logic [3:0]              sum;
  logic [2:0]              win;
  logic [DATA_WIDTH-1:0]   win_data;

  // Rotate the request vector so bit 0 is the slot after the last winner.
  always_comb begin
    dbl   = {req_valid, req_valid};
    rot   = N_REQ'(dbl >> (4'(last_q) + 4'd1));
    found = 1'b0;
    pos   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!found && rot[i]) begin
        found = 1'b1;
        pos   = 3'(i);
      end
    end
    sum = 4'(last_q) + 4'(pos) + 4'd1;
    if (sum >= 4'(N_REQ)) begin
      sum = sum - 4'(N_REQ);
    end
    win      = sum[2:0];
    win_data = DATA_WIDTH'(req_data >> (int'(win) * DATA_WIDTH));
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    grant_d = grant_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    if (err_clear) begin
      err_d = 1'b0;
    end
    unique case (state_q)
      IDLE: begin
        if (found && !tx_busy) begin
          data_d  = win_data;
          grant_d = win;
          last_d  = win;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = '0;
        state_d = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (tx_busy) begin
          state_d = WAIT_DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
          // Give up on this byte; it is already acked, so no retry.
          if (cnt_d == CW'(ACK_TIMEOUT - 1)) begin
            err_d   = 1'b1;
            state_d = IDLE;
          end
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      last_q  <= 3'(N_REQ - 1);
      grant_q <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      grant_q <= grant_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign tx_send     = (state_q == ISSUE);
  assign req_ack     = tx_send ? (N_REQ'(1) << grant_q) : '0;
  assign tx_data     = data_q;
  assign grant_id    = grant_q;
  assign active      = (state_q != IDLE);
  assign timeout_err = err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter with a simple transmitter model.
// Expected grants are queued at stimulus time and matched against observed sends.
`timescale 1ns/1ps
module tb_uart_tx_arbiter;

  localparam int AT = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  req_valid = '0;
  logic [31:0] req_data = '0;
  logic [3:0]  req_ack;
  logic        tx_busy;
  logic [7:0]  tx_data;
  logic        tx_send;
  logic [2:0]  grant_id;
  logic        active;
  logic        err_clear = 1'b0;
  logic        timeout_err;

  logic tm_busy;
  logic tm_pend;
  int   tm_cnt;
  logic force_busy = 1'b0;
  bit   tm_en = 1'b1;
  int   tm_delay = 2;
  int   tm_len = 10;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  typedef struct {
    logic [2:0] gid;
    logic [7:0] data;
  } exp_t;

  typedef struct {
    logic [2:0] gid;
    logic [7:0] data;
    logic [3:0] ack;
    logic       busy;
    int         cyc;
  } obs_t;

  exp_t exp_q[$];
  obs_t obs_q[$];

  uart_tx_arbiter #(
    .N_REQ(4),
    .DATA_WIDTH(8),
    .ACK_TIMEOUT(AT)
  ) dut (
    .clk(clk),
    .reset(reset),
    .req_valid(req_valid),
    .req_data(req_data),
    .req_ack(req_ack),
    .tx_busy(tx_busy),
    .tx_data(tx_data),
    .tx_send(tx_send),
    .grant_id(grant_id),
    .active(active),
    .err_clear(err_clear),
    .timeout_err(timeout_err)
  );

  assign tx_busy = tm_busy | force_busy;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin : monitor
    obs_t o;
    if (tx_send === 1'b1) begin
      o.gid  = grant_id;
      o.data = tx_data;
      o.ack  = req_ack;
      o.busy = tx_busy;
      o.cyc  = cyc;
      obs_q.push_back(o);
    end
  end

  // Transmitter: busy rises tm_delay cycles after send, lasts tm_len cycles.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      tm_busy <= 1'b0;
      tm_pend <= 1'b0;
      tm_cnt  <= 0;
    end else if (tx_send && tm_en) begin
      tm_pend <= 1'b1;
      tm_cnt  <= tm_delay;
    end else if (tm_pend) begin
      if (tm_cnt <= 1) begin
        tm_pend <= 1'b0;
        tm_busy <= 1'b1;
        tm_cnt  <= tm_len;
      end else begin
        tm_cnt <= tm_cnt - 1;
      end
    end else if (tm_busy) begin
      if (tm_cnt <= 1) tm_busy <= 1'b0;
      else tm_cnt <= tm_cnt - 1;
    end
  end

  task automatic push_exp(input logic [2:0] g, input logic [7:0] d);
    exp_t e;
    e.gid  = g;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic wait_sends(input int n, input int budget, input bit drop,
                            input string nm);
    int k;
    k = 0;
    while (obs_q.size() < n && k < budget) begin
      @(negedge clk);
      #1;
      if (drop) req_valid = req_valid & ~req_ack;
      k++;
    end
    total++;
    if (obs_q.size() < n) begin
      bad++;
      $display("FAIL %s: sends=%0d want %0d within %0d cycles",
               nm, obs_q.size(), n, budget);
    end
  endtask

  task automatic wait_idle(input int budget, input string nm);
    int k;
    k = 0;
    while ((active || tx_busy) && k < budget) begin
      @(negedge clk);
      #1;
      k++;
    end
    total++;
    if (active || tx_busy) begin
      bad++;
      $display("FAIL %s: active=%b busy=%b want 0 0 within %0d cycles",
               nm, active, tx_busy, budget);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #1;
    total++;
    if (tx_data !== 8'h00) begin
      bad++; $display("FAIL reset_tx_data: got %h want 00", tx_data);
    end
    total++;
    if (tx_send !== 1'b0) begin
      bad++; $display("FAIL reset_tx_send: got %b want 0", tx_send);
    end
    total++;
    if (req_ack !== 4'b0000) begin
      bad++; $display("FAIL reset_req_ack: got %b want 0000", req_ack);
    end
    total++;
    if (grant_id !== 3'd0) begin
      bad++; $display("FAIL reset_grant_id: got %0d want 0", grant_id);
    end
    total++;
    if (active !== 1'b0) begin
      bad++; $display("FAIL reset_active: got %b want 0", active);
    end
    total++;
    if (timeout_err !== 1'b0) begin
      bad++; $display("FAIL reset_timeout_err: got %b want 0", timeout_err);
    end
    #99;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_single();
    exp_t e;
    obs_t o;
    int   c;
    exp_q.delete();
    obs_q.delete();
    tm_en = 1'b1;
    tm_delay = 2;
    tm_len = 10;
    req_data[7:0] = 8'hAA;
    req_valid = 4'b0001;
    c = cyc;
    push_exp(3'd0, 8'hAA);
    wait_sends(1, 20, 1'b1, "single_send");
    total++;
    if (obs_q.size() > 0 && obs_q[0].cyc != c + 1) begin
      bad++;
      $display("FAIL single_latency: send at cycle %0d want %0d",
               obs_q[0].cyc, c + 1);
    end
    wait_idle(60, "single_idle");
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      total++;
      if (obs_q.size() == 0) begin
        bad++;
        $display("FAIL single_send_missing: want gid=%0d data=%h", e.gid, e.data);
      end else begin
        o = obs_q.pop_front();
        if (o.gid !== e.gid || o.data !== e.data ||
            o.ack !== (4'b0001 << e.gid) || o.busy !== 1'b0) begin
          bad++;
          $display("FAIL single_send: got gid=%0d data=%h ack=%b busy=%b want gid=%0d data=%h ack=%b busy=0",
                   o.gid, o.data, o.ack, o.busy, e.gid, e.data, 4'b0001 << e.gid);
        end
      end
    end
    total++;
    if (obs_q.size() != 0) begin
      bad++; $display("FAIL single_extra: got %0d extra sends want 0", obs_q.size());
    end
    total++;
    if (active !== 1'b0) begin
      bad++; $display("FAIL single_active_end: got %b want 0", active);
    end
  endtask

  task automatic test_round_robin();
    exp_t e;
    obs_t o;
    int   prev;
    do_reset();
    exp_q.delete();
    obs_q.delete();
    req_data = {8'h43, 8'h32, 8'h21, 8'h10};
    req_valid = 4'b1111;
    push_exp(3'd0, 8'h10);
    push_exp(3'd1, 8'h21);
    push_exp(3'd2, 8'h32);
    push_exp(3'd3, 8'h43);
    wait_sends(4, 200, 1'b1, "rr_sends");
    wait_idle(60, "rr_idle");
    prev = -1000;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      total++;
      if (obs_q.size() == 0) begin
        bad++;
        $display("FAIL rr_send_missing: want gid=%0d data=%h", e.gid, e.data);
      end else begin
        o = obs_q.pop_front();
        if (o.gid !== e.gid || o.data !== e.data ||
            o.ack !== (4'b0001 << e.gid) || o.busy !== 1'b0 ||
            o.cyc - prev < 3 + tm_len) begin
          bad++;
          $display("FAIL rr_send: got gid=%0d data=%h ack=%b busy=%b gap=%0d want gid=%0d data=%h ack=%b busy=0 gap>=%0d",
                   o.gid, o.data, o.ack, o.busy, o.cyc - prev,
                   e.gid, e.data, 4'b0001 << e.gid, 3 + tm_len);
        end
        prev = o.cyc;
      end
    end
    total++;
    if (obs_q.size() != 0) begin
      bad++; $display("FAIL rr_extra: got %0d extra sends want 0", obs_q.size());
    end
  endtask

  task automatic test_fairness();
    exp_t e;
    obs_t o;
    exp_q.delete();
    obs_q.delete();
    req_data = {8'h43, 8'h32, 8'h21, 8'h10};
    req_valid = 4'b0101;
    push_exp(3'd0, 8'h10);
    push_exp(3'd2, 8'h32);
    push_exp(3'd0, 8'h10);
    push_exp(3'd2, 8'h32);
    wait_sends(4, 200, 1'b0, "fair_sends");
    req_valid = 4'b0000;
    wait_idle(60, "fair_idle");
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      total++;
      if (obs_q.size() == 0) begin
        bad++;
        $display("FAIL fair_send_missing: want gid=%0d data=%h", e.gid, e.data);
      end else begin
        o = obs_q.pop_front();
        if (o.gid !== e.gid || o.data !== e.data ||
            o.ack !== (4'b0001 << e.gid) || o.busy !== 1'b0) begin
          bad++;
          $display("FAIL fair_send: got gid=%0d data=%h ack=%b busy=%b want gid=%0d data=%h ack=%b busy=0",
                   o.gid, o.data, o.ack, o.busy, e.gid, e.data, 4'b0001 << e.gid);
        end
      end
    end
    total++;
    if (obs_q.size() != 0) begin
      bad++; $display("FAIL fair_extra: got %0d extra sends want 0", obs_q.size());
    end
  endtask

  task automatic test_timeout();
    exp_t e;
    obs_t o;
    int   c;
    int   k;
    exp_q.delete();
    obs_q.delete();
    tm_en = 1'b0;
    req_data[15:8] = 8'hC3;
    req_valid = 4'b0010;
    push_exp(3'd1, 8'hC3);
    wait_sends(1, 20, 1'b1, "to_send");
    c = (obs_q.size() > 0) ? obs_q[0].cyc : cyc;
    k = 0;
    while (!timeout_err && k < 40) begin
      @(negedge clk);
      #1;
      k++;
    end
    total++;
    if (timeout_err !== 1'b1 || cyc - c != AT) begin
      bad++;
      $display("FAIL to_latency: err=%b after %0d cycles want 1 after %0d",
               timeout_err, cyc - c, AT);
    end
    total++;
    if (active !== 1'b0) begin
      bad++; $display("FAIL to_idle: active=%b want 0", active);
    end
    tm_en = 1'b1;
    req_data[31:24] = 8'h3C;
    req_valid = 4'b1000;
    push_exp(3'd3, 8'h3C);
    wait_sends(2, 20, 1'b1, "to_next_send");
    wait_idle(60, "to_next_idle");
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      total++;
      if (obs_q.size() == 0) begin
        bad++;
        $display("FAIL to_send_missing: want gid=%0d data=%h", e.gid, e.data);
      end else begin
        o = obs_q.pop_front();
        if (o.gid !== e.gid || o.data !== e.data ||
            o.ack !== (4'b0001 << e.gid) || o.busy !== 1'b0) begin
          bad++;
          $display("FAIL to_send: got gid=%0d data=%h ack=%b busy=%b want gid=%0d data=%h ack=%b busy=0",
                   o.gid, o.data, o.ack, o.busy, e.gid, e.data, 4'b0001 << e.gid);
        end
      end
    end
    total++;
    if (timeout_err !== 1'b1) begin
      bad++; $display("FAIL to_sticky: err=%b want 1", timeout_err);
    end
    err_clear = 1'b1;
    @(negedge clk);
    #1;
    err_clear = 1'b0;
    total++;
    if (timeout_err !== 1'b0) begin
      bad++; $display("FAIL to_clear: err=%b want 0", timeout_err);
    end
  endtask

  task automatic test_foreign_busy();
    exp_t e;
    obs_t o;
    int   c;
    bit   ok;
    exp_q.delete();
    obs_q.delete();
    force_busy = 1'b1;
    req_data[15:8] = 8'h5A;
    req_valid = 4'b0010;
    ok = 1'b1;
    repeat (10) begin
      @(negedge clk);
      #1;
      if (req_ack !== 4'b0000 || tx_send !== 1'b0 || active !== 1'b0) ok = 1'b0;
    end
    total++;
    if (!ok || obs_q.size() != 0) begin
      bad++;
      $display("FAIL fb_hold: ok=%b sends=%0d want ok=1 sends=0", ok, obs_q.size());
    end
    c = cyc;
    force_busy = 1'b0;
    push_exp(3'd1, 8'h5A);
    wait_sends(1, 20, 1'b1, "fb_send");
    total++;
    if (obs_q.size() > 0 && obs_q[0].cyc != c + 1) begin
      bad++;
      $display("FAIL fb_latency: send at cycle %0d want %0d", obs_q[0].cyc, c + 1);
    end
    wait_idle(60, "fb_idle");
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      total++;
      if (obs_q.size() == 0) begin
        bad++;
        $display("FAIL fb_send_missing: want gid=%0d data=%h", e.gid, e.data);
      end else begin
        o = obs_q.pop_front();
        if (o.gid !== e.gid || o.data !== e.data ||
            o.ack !== (4'b0001 << e.gid) || o.busy !== 1'b0) begin
          bad++;
          $display("FAIL fb_send: got gid=%0d data=%h ack=%b busy=%b want gid=%0d data=%h ack=%b busy=0",
                   o.gid, o.data, o.ack, o.busy, e.gid, e.data, 4'b0001 << e.gid);
        end
      end
    end
    total++;
    if (obs_q.size() != 0) begin
      bad++; $display("FAIL fb_extra: got %0d extra sends want 0", obs_q.size());
    end
  endtask

  task automatic test_reset_mid_frame();
    exp_t e;
    obs_t o;
    int   k;
    exp_q.delete();
    obs_q.delete();
    tm_len = 20;
    req_data[7:0] = 8'h77;
    req_data[23:16] = 8'h99;
    req_valid = 4'b0001;
    k = 0;
    while (!(active && tm_busy) && k < 40) begin
      @(negedge clk);
      #1;
      req_valid = req_valid & ~req_ack;
      k++;
    end
    total++;
    if (!(active && tm_busy)) begin
      bad++;
      $display("FAIL rm_frame: active=%b busy=%b want 1 1", active, tm_busy);
    end
    @(negedge clk);
    #1;
    obs_q.delete();
    req_valid = 4'b0101;
    #2;
    reset = 1'b0;
    #1;
    total++;
    if (tx_data !== 8'h00 || tx_send !== 1'b0 || req_ack !== 4'b0000 ||
        grant_id !== 3'd0 || active !== 1'b0 || timeout_err !== 1'b0) begin
      bad++;
      $display("FAIL rm_async: data=%h send=%b ack=%b gid=%0d active=%b err=%b want all 0",
               tx_data, tx_send, req_ack, grant_id, active, timeout_err);
    end
    @(negedge clk);
    reset = 1'b1;
    tm_len = 10;
    push_exp(3'd0, 8'h77);
    push_exp(3'd2, 8'h99);
    wait_sends(2, 100, 1'b1, "rm_sends");
    wait_idle(60, "rm_idle");
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      total++;
      if (obs_q.size() == 0) begin
        bad++;
        $display("FAIL rm_send_missing: want gid=%0d data=%h", e.gid, e.data);
      end else begin
        o = obs_q.pop_front();
        if (o.gid !== e.gid || o.data !== e.data ||
            o.ack !== (4'b0001 << e.gid) || o.busy !== 1'b0) begin
          bad++;
          $display("FAIL rm_send: got gid=%0d data=%h ack=%b busy=%b want gid=%0d data=%h ack=%b busy=0",
                   o.gid, o.data, o.ack, o.busy, e.gid, e.data, 4'b0001 << e.gid);
        end
      end
    end
    total++;
    if (obs_q.size() != 0) begin
      bad++; $display("FAIL rm_extra: got %0d extra sends want 0", obs_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_fairness();
    test_timeout();
    test_foreign_busy();
    test_reset_mid_frame();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one uart_transmitter (data/send/busy interface) between N_REQ byte producers inside an FPGA design.
- Round-robin arbitration, one byte per grant.
- Drives data/send; tracks busy through a full frame before the next grant.
- Flags a transmitter that fails to acknowledge a send.

Parameters:
- N_REQ, 4, number of requesters (2..8)
- DATA_WIDTH, 8, byte width, matches uart_transmitter data
- ACK_TIMEOUT, 16, max clk cycles from send pulse to tx_busy rising before timeout

Ports:
- clk  input  1  system clock; all state on rising edge
- reset  input  1  asynchronous, active-low reset (0 = reset)
- req_valid  input  N_REQ  per-requester byte-pending; held until matching req_ack
- req_data  input  N_REQ*DATA_WIDTH  flattened; requester i at bits [i*DATA_WIDTH +: DATA_WIDTH]; stable while req_valid[i]=1
- req_ack  output  N_REQ  one-hot, one-cycle pulse; byte accepted
- tx_busy  input  1  busy from uart_transmitter
- tx_data  output  DATA_WIDTH  to uart_transmitter data; registered
- tx_send  output  1  to uart_transmitter send; one-cycle pulse
- grant_id  output  3  index of last/current granted requester
- active  output  1  1 whenever state != IDLE
- err_clear  input  1  synchronous clear of timeout_err
- timeout_err  output  1  sticky; set on ACK_TIMEOUT expiry

Behaviour:
- Reset (reset=0, async) values:
  - tx_data=0, tx_send=0, req_ack=0, grant_id=0, active=0, timeout_err=0
  - state=IDLE
  - rr pointer last=N_REQ-1, so requester 0 has first priority
  - Takes effect immediately, including mid-frame.
- FSM states: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE.
- IDLE:
  - Arbitrates only when |req_valid=1 and tx_busy=0.
  - Winner = first i with req_valid[i]=1, scanning last+1, last+2, … mod N_REQ.
  - On grant edge: tx_data<=req_data[winner], grant_id<=winner, last<=winner, -> ISSUE.
  - If tx_busy=1 in IDLE (foreign traffic), no grant; stay IDLE.
- ISSUE (exactly 1 cycle):
  - tx_send=1 and req_ack[grant_id]=1 this cycle.
  - Clear timeout counter; -> WAIT_BUSY.
  - Latency: req_valid seen in IDLE at edge k -> tx_send and req_ack high during cycle k+1.
- WAIT_BUSY:
  - tx_busy=1 -> WAIT_DONE.
  - Otherwise counter++.
  - When counter reaches ACK_TIMEOUT-1 with tx_busy still 0: timeout_err<=1, -> IDLE, no retry; byte counts as consumed.
- WAIT_DONE:
  - Wait for tx_busy=0, then -> IDLE.
  - No timeout; frame length is owned by the transmitter.
- Requester side:
  - A requester may drop req_valid only after its ack.
  - Dropping earlier is a protocol violation; the arbiter still completes any grant already made.
- tx_data holds its value until the next grant.
- timeout_err:
  - err_clear=1 clears it.
  - Set wins over clear in the same cycle.
- grant_id is zero-extended when N_REQ<8.
- Back-to-back: minimum 3 cycles + busy duration between successive tx_send pulses; tx_send never asserted while tx_busy=1.

Test Plan:
1. Reset pulse low 100 ns; req_valid=4'b0001, req_data[7:0]=8'hAA; transmitter model busy 2 cycles after send for 10 bit-times -> one tx_send, tx_data=8'hAA, req_ack=4'b0001, grant_id=0; IDLE after busy falls.
2. req_valid=4'b1111 held, data 8'h10/8'h21/8'h32/8'h43, requesters drop valid on ack -> tx_data sequence 10,21,32,43, grant order 0,1,2,3, exactly 4 send pulses.
3. Fairness: req_valid[0] and [2] kept permanently high -> grants alternate 0,2,0,2; requester 2 never starved.
4. Transmitter model never raises busy -> timeout_err=1 exactly ACK_TIMEOUT cycles after send; state returns to IDLE; next request still served; err_clear=1 for one cycle -> timeout_err=0.
5. tx_busy forced 1 while IDLE with req_valid=4'b0010 -> no send or ack until tx_busy=0, then grant 1 on the next edge.
6. reset driven low during WAIT_DONE -> outputs at reset values immediately (async); after release, pending requester 0 is served first.
